fifo_ptr_flags: RTL and testbench
=================================

Name: fifo_ptr_flags

Overview:
- Single-clock virtual-FIFO pointer and status unit; holds no data storage.
- Write side advances a binary wrap pointer by one entry per accepted write.
- Read (drain) side advances a read pointer by a variable size per accepted request.
- Produces occupancy count and full/empty/almost flags. Used as flow-control/pre-reservation logic in front of stream write engines.

Parameters:
- DEPTH, 512, virtual FIFO depth in entries; must be a power of two and at least 4.
- ALMOST_WR_MARGIN, 1, almost-full asserts when count >= DEPTH-ALMOST_WR_MARGIN.
- ALMOST_RD_MARGIN, 1, almost-empty asserts when count <= ALMOST_RD_MARGIN.
- REGISTERED, 1. 1 = flags/count registered from next-state pointers. 0 = flags/count combinational from current pointers.
- AW, $clog2(DEPTH), address width; pointers are AW+1 bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_valid  in  1  one entry written.
- wr_ready  out  1  equals !wr_full.
- rd_valid  in  1  drain request.
- rd_size  in  8  entries to drain, zero-extended to AW+1.
- rd_ready  out  1  equals !rd_empty.
- count  out  AW+1  current occupancy, 0..DEPTH.
- wr_full  out  1  count == DEPTH.
- wr_almost_full  out  1  almost-full flag.
- rd_empty  out  1  count == 0.
- rd_almost_empty  out  1  almost-empty flag.

Behaviour:
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - wr_full = 0, wr_almost_full = 0.
  - rd_empty = 1, rd_almost_empty = 1.
  - wr_ready = 1, rd_ready = 0.
  - Reset asserted mid-operation clears all state immediately, regardless of clock.
- Write accept: wr_valid && wr_ready. The write pointer increments by 1 at the clock edge.
- Write pointer rules:
  - Lower AW bits wrap from DEPTH-1 to 0 and toggle the MSB.
  - next_wr_ptr is available combinationally.
  - wr_valid while full is ignored; no pointer change.
- Read accept: rd_valid && rd_ready.
  - drain = min(rd_size, count); rd_ptr += drain, modulo 2^(AW+1).
  - rd_size = 0 is accepted with no change.
  - Over-size requests saturate at count; the pointer never passes wr_ptr.
- Simultaneous write and read in one cycle:
  - Both apply; next count = count + 1 - drain.
  - drain is computed from the pre-write count; the same-cycle write is not drainable.
- Count and flags:
  - count = wr_ptr - rd_ptr (AW+1-bit subtract).
  - full: address bits equal and MSBs differ.
  - empty: pointers fully equal.
- REGISTERED=1:
  - Flags and count are registered from next_wr_ptr/next_rd_ptr.
  - After an edge they reflect the state including that edge's updates; no extra cycle of lag.
- REGISTERED=0: flags and count are combinational from the registered pointers. This setting avoids a ready→accept→flag loop.
- No combinational path exists from rd_size or valid inputs to the ready outputs in either mode.

Decomposition:
- Shared package stream_pkg holds:
  - a pointer-width helper function (AW+1 from DEPTH);
  - a constant for the rd_size width (8).
- One natural sub-module: wrap_counter_bin, the AW+1-bit wrap counter with enable and combinational next output, used for the write pointer.
- Full/empty/count logic stays inline.

Test Plan:
- Reset: rst_n low mid-traffic with count=5 → next cycle count=0, rd_empty=1, rd_almost_empty=1, wr_ready=1, rd_ready=0.
- Fill (DEPTH=8): 8 writes → count steps 1..8, wr_almost_full at count=7, wr_full=1 and wr_ready=0 at count=8; a 9th wr_valid leaves count at 8.
- Variable drain: with count=8, rd_size=3 → count=5; rd_size=5 → count=0, rd_empty=1; rd_almost_empty=1 when count ≤1.
- Simultaneous: count=4, write plus rd_size=2 in one cycle → count=3; count=0, write plus rd_size=1 → read not accepted, count=1.
- Oversize/zero: count=2, rd_size=10 → count=0, rd_ptr advanced by 2; rd_size=0 with count=3 → count stays 3.
- Wrap-around: 20 cycles of write plus single-entry drain from count=1 → pointer MSB toggles, count stays 1, no false full/empty; repeat with REGISTERED=0 and check identical count sequence.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared width helpers and constants for the stream flow-control blocks.
package stream_pkg;

   localparam int RD_SIZE_W = 8;

   // Pointer width: address bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/wrap_counter_bin.sv
// Binary wrap counter with enable; the next value is exported combinationally.
module wrap_counter_bin #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cnt_nxt
);

   // Plain +1 wraps the address bits and toggles the MSB for power-of-two depths.
   assign cnt_nxt = en ? cnt + W'(1) : cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nxt;
   end

endmodule

// File: rtl/fifo_ptr_flags.sv
// Virtual-FIFO pointer/flag unit: unit-step writes, variable-size saturating drains.
module fifo_ptr_flags
   import stream_pkg::*;
#(
   parameter int DEPTH            = 512,
   parameter int ALMOST_WR_MARGIN = 1,
   parameter int ALMOST_RD_MARGIN = 1,
   parameter bit REGISTERED       = 1'b1,
   parameter int AW               = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic                 rd_valid,
   input  logic [RD_SIZE_W-1:0] rd_size,
   output logic                 rd_ready,
   output logic [AW:0]          count,
   output logic                 wr_full,
   output logic                 wr_almost_full,
   output logic                 rd_empty,
   output logic                 rd_almost_empty
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = (PW > RD_SIZE_W) ? PW : RD_SIZE_W;
   localparam logic [PW-1:0] AF_TH = PW'(DEPTH - ALMOST_WR_MARGIN);
   localparam logic [PW-1:0] AE_TH = PW'(ALMOST_RD_MARGIN);

   logic [PW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
   logic [PW-1:0] cur_cnt, drain;
   logic [CW-1:0] size_x, cnt_x;
   logic          wr_acc, rd_acc;

   assign wr_ready = !wr_full;
   assign rd_ready = !rd_empty;
   assign wr_acc   = wr_valid && wr_ready;
   assign rd_acc   = rd_valid && rd_ready;
   assign cur_cnt  = wr_ptr - rd_ptr;

   wrap_counter_bin #(.W(PW)) u_wr_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (wr_acc),
      .cnt     (wr_ptr),
      .cnt_nxt (wr_ptr_nxt)
   );

   // Drain saturates at the pre-write occupancy; compare wide so large rd_size is not truncated.
   always_comb begin
      size_x = CW'(rd_size);
      cnt_x  = CW'(cur_cnt);
      drain  = (size_x < cnt_x) ? PW'(size_x) : cur_cnt;
      rd_ptr_nxt = rd_acc ? rd_ptr + drain : rd_ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_ptr <= '0;
      else        rd_ptr <= rd_ptr_nxt;
   end

   logic [PW-1:0] f_wr, f_rd, f_cnt;
   logic          f_full, f_empty, f_af, f_ae;

   assign f_wr = REGISTERED ? wr_ptr_nxt : wr_ptr;
   assign f_rd = REGISTERED ? rd_ptr_nxt : rd_ptr;

   always_comb begin
      f_cnt   = f_wr - f_rd;
      f_full  = (f_wr[PW-2:0] == f_rd[PW-2:0]) && (f_wr[PW-1] != f_rd[PW-1]);
      f_empty = (f_wr == f_rd);
      f_af    = (f_cnt >= AF_TH);
      f_ae    = (f_cnt <= AE_TH);
   end

   generate
      if (REGISTERED) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               count           <= '0;
               wr_full         <= 1'b0;
               wr_almost_full  <= 1'b0;
               rd_empty        <= 1'b1;
               rd_almost_empty <= 1'b1;
            end else begin
               count           <= f_cnt;
               wr_full         <= f_full;
               wr_almost_full  <= f_af;
               rd_empty        <= f_empty;
               rd_almost_empty <= f_ae;
            end
         end
      end else begin : g_comb
         assign count           = f_cnt;
         assign wr_full         = f_full;
         assign wr_almost_full  = f_af;
         assign rd_empty        = f_empty;
         assign rd_almost_empty = f_ae;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_ptr_flags.sv
// Directed bench: DEPTH=8, registered and combinational variants driven in lockstep.
module tb_fifo_ptr_flags;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid, rd_valid;
   logic [7:0] rd_size;

   logic [AW:0] count_r, count_c;
   logic wr_ready_r, rd_ready_r, full_r, af_r, empty_r, ae_r;
   logic wr_ready_c, rd_ready_c, full_c, af_c, empty_c, ae_c;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   fifo_ptr_flags #(.DEPTH(DEPTH), .REGISTERED(1'b1)) u_reg (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_r),
      .rd_valid(rd_valid), .rd_size(rd_size), .rd_ready(rd_ready_r), .count(count_r),
      .wr_full(full_r), .wr_almost_full(af_r), .rd_empty(empty_r), .rd_almost_empty(ae_r)
   );

   fifo_ptr_flags #(.DEPTH(DEPTH), .REGISTERED(1'b0)) u_comb (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_c),
      .rd_valid(rd_valid), .rd_size(rd_size), .rd_ready(rd_ready_c), .count(count_c),
      .wr_full(full_c), .wr_almost_full(af_c), .rd_empty(empty_c), .rd_almost_empty(ae_c)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Expected flags follow directly from the hand-tracked occupancy c.
   task automatic chk_state(input string tag, input int c);
      chk({tag, ".count_r"},  int'(count_r),    c);
      chk({tag, ".count_c"},  int'(count_c),    c);
      chk({tag, ".full_r"},   int'(full_r),     int'(c == DEPTH));
      chk({tag, ".full_c"},   int'(full_c),     int'(c == DEPTH));
      chk({tag, ".wrdy_r"},   int'(wr_ready_r), int'(c != DEPTH));
      chk({tag, ".wrdy_c"},   int'(wr_ready_c), int'(c != DEPTH));
      chk({tag, ".empty_r"},  int'(empty_r),    int'(c == 0));
      chk({tag, ".empty_c"},  int'(empty_c),    int'(c == 0));
      chk({tag, ".rrdy_r"},   int'(rd_ready_r), int'(c != 0));
      chk({tag, ".rrdy_c"},   int'(rd_ready_c), int'(c != 0));
      chk({tag, ".af_r"},     int'(af_r),       int'(c >= DEPTH - 1));
      chk({tag, ".af_c"},     int'(af_c),       int'(c >= DEPTH - 1));
      chk({tag, ".ae_r"},     int'(ae_r),       int'(c <= 1));
      chk({tag, ".ae_c"},     int'(ae_c),       int'(c <= 1));
   endtask

   task automatic step(input logic wv, input logic rv, input int rs);
      wr_valid = wv;
      rd_valid = rv;
      rd_size  = 8'(rs);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      rd_size  = 8'd0;
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rd_size = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_state("reset", 0);
      rst_n = 1'b1;

      // Fill to full, then one extra write that must be ignored
      for (int k = 1; k <= DEPTH; k++) begin
         step(1'b1, 1'b0, 0);
         chk_state($sformatf("fill%0d", k), k);
      end
      step(1'b1, 1'b0, 0);
      chk_state("write_when_full", 8);

      step(1'b0, 1'b1, 3);
      chk_state("drain3", 5);
      step(1'b0, 1'b1, 5);
      chk_state("drain5", 0);

      // Simultaneous write and drain
      repeat (4) step(1'b1, 1'b0, 0);
      chk_state("refill4", 4);
      step(1'b1, 1'b1, 2);
      chk_state("wr_rd2", 3);
      step(1'b0, 1'b1, 3);
      chk_state("drain_all", 0);
      step(1'b1, 1'b1, 1);
      chk_state("wr_rd_empty", 1);

      // Oversize and zero-size drains
      step(1'b1, 1'b0, 0);
      chk_state("count2", 2);
      step(1'b0, 1'b1, 10);
      chk_state("oversize", 0);
      step(1'b1, 1'b0, 0);
      chk_state("after_oversize", 1);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      chk_state("count3", 3);
      step(1'b0, 1'b1, 0);
      chk_state("size0", 3);

      // Wrap-around with steady occupancy of one
      step(1'b0, 1'b1, 2);
      chk_state("to1", 1);
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 1'b1, 1);
         chk_state($sformatf("wrap%0d", k), 1);
      end

      // Asynchronous reset mid-traffic at count=5
      repeat (4) step(1'b1, 1'b0, 0);
      chk_state("pre_rst", 5);
      wr_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("async_rst", 0);
      @(posedge clk);
      #1;
      chk_state("rst_held", 0);
      wr_valid = 1'b0;
      rst_n = 1'b1;
      step(1'b1, 1'b0, 0);
      chk_state("post_rst", 1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
